// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, state and datapath-select encodings for the MIPS multicycle control
// Purpose: constants used by both the control unit and the datapath muxes so that
//          select encodings cannot drift between the two sides.
// Ports:   none (package)
`timescale 1ns/1ps
package mips_ctrl_pkg;

  // IR[31:26] opcodes understood by the control unit
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // 4-bit state encoding; codes 14 and 15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_MEM_WB    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  // ALU operand-B mux select
  localparam logic [1:0] ALU_SRC_B_REG  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd2;
  localparam logic [1:0] ALU_SRC_B_BOFF = 2'd3;

  // PC source mux select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // ALU control
  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  // States that hold a memory strobe for MEM_LATENCY cycles
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - memory-access wait sequencer for the multicycle control unit
// Purpose: counts cycles spent in a memory wait state and flags the last one.
// Ports:   clk   - system clock, rising edge
//          reset - asynchronous, active-high
//          start - high while the control FSM sits in a wait state
//          done  - high in the final cycle of the access (count == MEM_LATENCY-1)
`timescale 1ns/1ps
module mem_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  logic [3:0] wait_cnt;

  assign done = start && (wait_cnt == LAST);

  // Count is zero outside wait states and is cleared on the last cycle, so
  // back-to-back wait states (MEM_WRITE -> FETCH) each start from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (start && !done) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control unit sequencing FETCH/DECODE/EXEC/MEM/WB for the multicycle MIPS datapath
// Purpose: decodes the IR opcode in DECODE and drives every datapath select and strobe.
// Ports:   clk, reset (async, active-high), opcode[5:0] (IR[31:26], used in DECODE only)
//          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
//          reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0],
//          illegal_op (held while in the absorbing ILLEGAL state)
`timescale 1ns/1ps
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  state_t state;
  state_t next_state;
  logic   store_op;   // lw/sw choice captured in DECODE
  logic   wait_done;

  mem_wait_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .start(is_wait_state(state)),
    .done (wait_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RESET;
      store_op <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        store_op <= (opcode == OP_SW);
      end
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_RESET:     next_state = S_FETCH;
      S_FETCH:     next_state = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: next_state = S_R_EXEC;
          OP_LW,
          OP_SW:    next_state = S_MEM_ADDR;
          OP_ADDI:  next_state = S_ADDI_EXEC;
          OP_BEQ:   next_state = S_BRANCH;
          OP_J:     next_state = S_JUMP;
          default:  next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  next_state = store_op ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = wait_done ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state = wait_done ? S_FETCH : S_MEM_WRITE;
      S_MEM_WB:    next_state = S_FETCH;
      S_R_EXEC:    next_state = S_R_WB;
      S_R_WB:      next_state = S_FETCH;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_ADDI_WB:   next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
      S_ILLEGAL:   next_state = S_ILLEGAL;
      default:     next_state = S_FETCH;   // unused encodings recover
    endcase
  end

  // Output decode from state and wait counter only; async reset therefore
  // drops every strobe in the same cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_SRC_B_REG;
    alu_op        = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_SRC_B_FOUR;
        ir_write  = wait_done;
        pc_write  = wait_done;
      end
      S_DECODE: begin
        alu_src_b = ALU_SRC_B_BOFF;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm at MEM_LATENCY 1, 2 and 3
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [5:0]  opc [3];
  logic [16:0] obs [3];

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];

  // Output vector layout (bit positions)
  localparam logic [16:0] PCW  = 17'h10000;
  localparam logic [16:0] PCWC = 17'h08000;
  localparam logic [16:0] IORD = 17'h04000;
  localparam logic [16:0] MR   = 17'h02000;
  localparam logic [16:0] MW   = 17'h01000;
  localparam logic [16:0] IRW  = 17'h00800;
  localparam logic [16:0] M2R  = 17'h00400;
  localparam logic [16:0] RDST = 17'h00200;
  localparam logic [16:0] RW   = 17'h00100;
  localparam logic [16:0] ASA  = 17'h00080;
  localparam logic [16:0] ILL  = 17'h00001;

  function automatic logic [16:0] asb(input int n);
    return 17'(n) << 5;
  endfunction
  function automatic logic [16:0] aop(input int n);
    return 17'(n) << 3;
  endfunction
  function automatic logic [16:0] psrc(input int n);
    return 17'(n) << 1;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
      logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
      logic [1:0] alu_src_b, alu_op, pc_source;
      multicycle_control_fsm #(.MEM_LATENCY(g + 1)) dut (
        .clk          (clk),
        .reset        (rst[g]),
        .opcode       (opc[g]),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .illegal_op   (illegal_op)
      );
      assign obs[g] = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, illegal_op};
    end
  endgenerate

  task automatic check(input string tag, input int k, input logic [16:0] e);
    checks++;
    assert (obs[k] === e) else begin
      errors++;
      $error("FAIL %s dut_L=%0d observed=%h expected=%h", tag, k + 1, obs[k], e);
    end
  endtask

  // Per-cycle expected outputs of one instruction, built phase by phase
  task automatic build(input logic [5:0] op, input int lat);
    exp_q.delete();
    for (int i = 0; i < lat; i++)
      exp_q.push_back(MR | asb(1) | ((i == lat - 1) ? (IRW | PCW) : 17'd0));
    exp_q.push_back(asb(3));
    case (op)
      6'h00: begin
        exp_q.push_back(ASA | asb(0) | aop(2));
        exp_q.push_back(RW | RDST);
      end
      6'h23: begin
        exp_q.push_back(ASA | asb(2));
        repeat (lat) exp_q.push_back(IORD | MR);
        exp_q.push_back(RW | M2R);
      end
      6'h2B: begin
        exp_q.push_back(ASA | asb(2));
        repeat (lat) exp_q.push_back(IORD | MW);
      end
      6'h08: begin
        exp_q.push_back(ASA | asb(2));
        exp_q.push_back(RW);
      end
      6'h04: exp_q.push_back(ASA | asb(0) | aop(1) | PCWC | psrc(1));
      6'h02: exp_q.push_back(PCW | psrc(2));
      default: exp_q.push_back(ILL);
    endcase
  endtask

  // Checks up to ncheck cycles (all when negative); opcode is scrambled once
  // DECODE is over, so only the DECODE-time value may matter.
  task automatic run_instr(input int k, input logic [5:0] op, input int ncheck);
    build(op, k + 1);
    opc[k] = op;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (ncheck >= 0 && c >= ncheck) break;
      @(negedge clk);
      check($sformatf("op%02h_cyc%0d", op, c), k, exp_q[c]);
      if (c == k + 2) opc[k] = 6'($urandom);
    end
  endtask

  // Asserts reset, checks outputs during and just after release (still RESET)
  task automatic reset_dut(input int k);
    rst[k] = 1'b1;
    #1 check("reset_hold", k, 17'd0);
    @(negedge clk);
    rst[k] = 1'b0;
    #1 check("reset_state", k, 17'd0);
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops[0] = 6'h00; legal_ops[1] = 6'h23; legal_ops[2] = 6'h2B;
    legal_ops[3] = 6'h08; legal_ops[4] = 6'h04; legal_ops[5] = 6'h02;
    rst = 3'b111;
    for (int i = 0; i < 3; i++) opc[i] = 6'h3F;
    repeat (2) @(negedge clk);

    // reset in the middle of a store, L=3
    reset_dut(2);
    run_instr(2, 6'h2B, 6);
    #2 rst[2] = 1'b1;
    #1 check("reset_mid_write", 2, 17'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    #1 check("reset_after_write", 2, 17'd0);
    run_instr(2, 6'h00, -1);

    // directed L=1: R-type, beq, j, sw
    reset_dut(0);
    run_instr(0, 6'h00, -1);
    run_instr(0, 6'h04, -1);
    run_instr(0, 6'h02, -1);
    run_instr(0, 6'h2B, -1);

    // directed L=2: lw
    reset_dut(1);
    run_instr(1, 6'h23, -1);
    run_instr(1, 6'h08, -1);

    // illegal opcode is absorbing until reset
    reset_dut(0);
    run_instr(0, 6'h3F, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opc[0] = 6'($urandom);
      check($sformatf("illegal_hold%0d", i), 0, ILL);
    end
    reset_dut(0);

    // random legal instruction streams at every latency
    for (int k = 0; k < 3; k++) begin
      reset_dut(k);
      repeat (15) run_instr(k, legal_ops[$urandom_range(0, 5)], -1);
      opc[k] = 6'h3F;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
